pad_stream_asym: RTL
====================

Name: pad_stream_asym

Overview:
- Parametrised successor to the single-pad zero-padding stream block in the inference engine `pd_block`.
- Receives a headered image stream (xres word, yres word, then raster pixels) and emits a headered stream with the padded dimensions.
- Pad amounts are independent for top, bottom, left and right. Pad value comes from a runtime port. Data width is configurable.
- Sits between the line reader and the convolution window generator.

Parameters:
- DATA_W, 16, stream word width; must be >= DIM_W.
- DIM_W, 12, width of the resolution fields and counters.
- PAD_TOP, 1, rows inserted above the image.
- PAD_BOTTOM, 1, rows inserted below the image.
- PAD_LEFT, 1, columns inserted before each row.
- PAD_RIGHT, 1, columns inserted after each row.

Ports:
- clock  in  1  single clock domain.
- clock_areset_n  in  1  reset; asynchronous, active-low.
- pad_value  in  DATA_W  pad word; sampled when the input sop header is accepted.
- si_ready  out  1  input ready.
- si_valid  in  1  input valid.
- si_sop  in  1  input start of packet.
- si_eop  in  1  input end of packet.
- si_data  in  DATA_W  input word.
- so_ready  in  1  output ready.
- so_valid  out  1  output valid.
- so_sop  out  1  output start of packet.
- so_eop  out  1  output end of packet.
- so_data  out  DATA_W  output word.
- err_frame  out  1  one-cycle error pulse; only present with the optional feature.

Behaviour:
- Handshake (both sides):
  - A transfer occurs on a cycle with valid & ready. Ready latency is 0.
  - so_* is a registered single-entry stage. Once so_valid is asserted, so_data, so_sop and so_eop hold until accepted.
  - The stage may load when ~so_valid | so_ready.
- Reset (asynchronous assert, synchronous deassert is the integrator's responsibility):
  - so_valid=0, so_sop=0, so_eop=0, so_data=0, err_frame=0, fsm=HDR_X, counters=0.
  - Reset mid-frame discards all state. Input words before the next si_sop are dropped while in HDR_X.
- State machine:
  - HDR_X:
    - si_ready=1. Accepted words without si_sop are dropped.
    - On an accepted word with si_sop: xres=si_data[DIM_W-1:0]; pad_value is latched; go to HDR_Y.
  - HDR_Y:
    - si_ready=1. On accept: yres=si_data[DIM_W-1:0]; go to OUT_X.
  - OUT_X:
    - si_ready=0. Load output word xres+PAD_LEFT+PAD_RIGHT, modulo 2^DIM_W, zero-extended to DATA_W, with so_sop=1.
    - Go to OUT_Y.
  - OUT_Y:
    - si_ready=0. Load output word yres+PAD_TOP+PAD_BOTTOM (same width rule).
    - so_eop=1 only if the padded pixel count is zero. In that case go to HDR_X, otherwise go to PIXEL.
    - count_x=count_y=0.
  - PIXEL: counters have DIM_W+1 bits; no wrap inside a frame.
    - Interior position: PAD_LEFT<=count_x<xres+PAD_LEFT and PAD_TOP<=count_y<yres+PAD_TOP.
    - Interior: si_ready = ~so_valid | so_ready. Load si_data when an input word is accepted.
    - Pad position: si_ready=0. Load the latched pad_value when the stage is free.
    - Counters advance only when a word is loaded into the output stage.
    - count_x wraps at xres+PAD_LEFT+PAD_RIGHT-1; count_y then increments.
    - Last position (both counters at max): load with so_eop=1 and go to HDR_X.
- Throughput: one word per cycle with so_ready held high, including across pad/interior boundaries.
- Latency: 1 cycle from input accept to so_valid.
- Zero dimensions:
  - xres=0 or yres=0 produces a frame made only of pad words, sized by the pads.
  - A zero-pad configuration with 0x0 produces a header-only frame.
- Input si_sop during PIXEL is treated as data and not restarted (behaviour without the optional feature).
- Input si_eop is ignored without the optional feature.

Optional Feature:
- Macro: PAD_STREAM_ASYM_FRAME_CHECK_EN.
- When defined:
  - err_frame port exists.
  - Early end: input si_eop accepted before the last interior pixel pulses err_frame. All remaining interior positions are filled with pad_value so the output frame stays full size.
  - Late end: the last interior pixel accepted without si_eop pulses err_frame. FSM enters DRAIN (si_ready=1, output idle) and discards input up to and including the next si_eop. It then completes the remaining pad positions of the frame and returns to HDR_X.
  - si_sop accepted in PIXEL is treated as an early end and raises the same pulse.
- When undefined: err_frame is absent, si_eop and mid-frame si_sop are ignored, and there is no DRAIN state.

Test Plan:
- Defaults (pad 1 all sides), input 2x2 data A,B,C,D, pad_value=0, so_ready=1:
  - Output headers 4 then 4 (sop on the first).
  - 16 pixels: A,B at pixel indices 5,6 and C,D at 9,10; all others 0; eop on pixel 15.
  - 18 consecutive valid cycles.
- Asymmetric pads (TOP=0, BOTTOM=2, LEFT=1, RIGHT=0), input 3x1 = 1,2,3, pad_value=16'h7FFF:
  - Headers 4,3.
  - Pixels 7FFF,1,2,3, then 8 words of 7FFF; eop on the last.
- Backpressure on the 2x2 default case: so_ready toggles 1,0,1,0. Required response:
  - No word lost or duplicated; so_data stable while so_valid & ~so_ready.
  - si_ready low at pad positions.
- Reset mid-frame: assert clock_areset_n=0 after the 7th output pixel. Required response:
  - so_valid drops immediately.
  - A new 1x1 frame (data 5) yields headers 3,3 and 9 pixels with 5 at index 4.
- Zero size: input 0x3 with default pads. Required response: headers 2,5 and 10 pad words, eop on the 10th.
- PAD_STREAM_ASYM_FRAME_CHECK_EN defined:
  - 2x2 frame with eop on the 2nd pixel: err_frame pulse; output still 16 pixels, with positions 9,10 = pad_value.
  - 2x2 frame with no eop followed by 2 extra words and eop: err_frame pulse; extra words discarded; the next frame is processed normally.

Source files
------------

// File: rtl/pad_stream_asym.sv
// rtl/pad_stream_asym.sv - headered image stream zero/constant padding with independent per-side pad amounts
//
// Ports:
//   clock, clock_areset_n          clock and asynchronous active-low reset
//   pad_value[DATA_W]              pad word, latched with the input sop header
//   si_valid/si_ready/si_sop/si_eop/si_data   input stream (xres, yres, raster pixels)
//   so_valid/so_ready/so_sop/so_eop/so_data   output stream (padded xres, padded yres, pixels)
//   err_frame                      one-cycle framing error pulse (PAD_STREAM_ASYM_FRAME_CHECK_EN only)
//
// Optional feature macro: PAD_STREAM_ASYM_FRAME_CHECK_EN
module pad_stream_asym #(
    parameter int DATA_W     = 16,
    parameter int DIM_W      = 12,
    parameter int PAD_TOP    = 1,
    parameter int PAD_BOTTOM = 1,
    parameter int PAD_LEFT   = 1,
    parameter int PAD_RIGHT  = 1
) (
    input  logic              clock,
    input  logic              clock_areset_n,
    input  logic [DATA_W-1:0] pad_value,
    output logic              si_ready,
    input  logic              si_valid,
    input  logic              si_sop,
    input  logic              si_eop,
    input  logic [DATA_W-1:0] si_data,
    input  logic              so_ready,
    output logic              so_valid,
    output logic              so_sop,
    output logic              so_eop,
    output logic [DATA_W-1:0] so_data
`ifdef PAD_STREAM_ASYM_FRAME_CHECK_EN
    ,
    output logic              err_frame
`endif
);

    localparam int CW = DIM_W + 1;

    typedef enum logic [2:0] {
        HDR_X,
        HDR_Y,
        OUT_X,
        OUT_Y,
        PIXEL
`ifdef PAD_STREAM_ASYM_FRAME_CHECK_EN
        ,
        DRAIN
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIM_W-1:0]  r_xres;
    logic [DIM_W-1:0]  r_yres;
    logic [DATA_W-1:0] r_pad;
    logic [CW-1:0]     r_cx;
    logic [CW-1:0]     r_cy;
    logic              r_so_valid;
    logic              r_so_sop;
    logic              r_so_eop;
    logic [DATA_W-1:0] r_so_data;

    logic [CW-1:0]     w_wx;
    logic [CW-1:0]     w_wy;
    logic [CW-1:0]     w_ix_hi;
    logic [CW-1:0]     w_iy_hi;
    logic              w_last_x;
    logic              w_last;
    logic              w_interior;
    logic              w_free;
    logic              w_early;
    logic              w_load;
    logic [DATA_W-1:0] w_ld_data;
    logic              w_ld_sop;
    logic              w_ld_eop;
    logic              w_adv;
    logic              w_cnt_clr;
    logic              w_cap_x;
    logic              w_cap_y;
    logic              w_err;
    logic              w_early_set;
    logic              w_unused;

`ifdef PAD_STREAM_ASYM_FRAME_CHECK_EN
    logic r_early;
    logic r_err;
    logic r_done;
    logic w_last_int;
    assign w_early    = r_early;
    assign err_frame  = r_err;
    assign w_last_int = (r_cx == w_ix_hi - CW'(1)) && (r_cy == w_iy_hi - CW'(1));
`else
    assign w_early = 1'b0;
`endif

    // si_eop only matters for the frame checker; keep it referenced otherwise.
    assign w_unused = &{1'b0, si_eop};

    assign w_wx    = {1'b0, r_xres} + CW'(PAD_LEFT) + CW'(PAD_RIGHT);
    assign w_wy    = {1'b0, r_yres} + CW'(PAD_TOP) + CW'(PAD_BOTTOM);
    assign w_ix_hi = {1'b0, r_xres} + CW'(PAD_LEFT);
    assign w_iy_hi = {1'b0, r_yres} + CW'(PAD_TOP);

    assign w_last_x   = (r_cx == w_wx - CW'(1));
    assign w_last     = w_last_x && (r_cy == w_wy - CW'(1));
    // After an early end every remaining interior position is emitted as pad.
    assign w_interior = (r_cx >= CW'(PAD_LEFT)) && (r_cx < w_ix_hi) &&
                        (r_cy >= CW'(PAD_TOP))  && (r_cy < w_iy_hi) && !w_early;
    assign w_free     = !r_so_valid || so_ready;

    always_comb begin
        w_state_nxt = r_state;
        si_ready    = 1'b0;
        w_load      = 1'b0;
        w_ld_data   = r_pad;
        w_ld_sop    = 1'b0;
        w_ld_eop    = 1'b0;
        w_adv       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cap_x     = 1'b0;
        w_cap_y     = 1'b0;
        w_err       = 1'b0;
        w_early_set = 1'b0;
        case (r_state)
            HDR_X: begin
                si_ready = 1'b1;
                if (si_valid && si_sop) begin
                    w_cap_x     = 1'b1;
                    w_state_nxt = HDR_Y;
                end
            end
            HDR_Y: begin
                si_ready = 1'b1;
                if (si_valid) begin
                    w_cap_y     = 1'b1;
                    w_state_nxt = OUT_X;
                end
            end
            OUT_X: begin
                if (w_free) begin
                    w_load      = 1'b1;
                    w_ld_data   = DATA_W'(w_wx[DIM_W-1:0]);
                    w_ld_sop    = 1'b1;
                    w_state_nxt = OUT_Y;
                end
            end
            OUT_Y: begin
                if (w_free) begin
                    w_load    = 1'b1;
                    w_ld_data = DATA_W'(w_wy[DIM_W-1:0]);
                    w_cnt_clr = 1'b1;
                    if (w_wx == '0 || w_wy == '0) begin
                        w_ld_eop    = 1'b1;
                        w_state_nxt = HDR_X;
                    end else begin
                        w_state_nxt = PIXEL;
                    end
                end
            end
            PIXEL: begin
                if (w_interior) begin
                    si_ready = w_free;
                    if (si_valid && w_free) begin
                        w_load    = 1'b1;
                        w_ld_data = si_data;
                    end
                end else if (w_free) begin
                    w_load = 1'b1;
                end
                if (w_load) begin
                    w_adv = 1'b1;
                    if (w_last) begin
                        w_ld_eop    = 1'b1;
                        w_state_nxt = HDR_X;
                    end
                end
`ifdef PAD_STREAM_ASYM_FRAME_CHECK_EN
                if (w_interior && si_valid && w_free) begin
                    if (!w_last_int && (si_eop || si_sop)) begin
                        w_err       = 1'b1;
                        w_early_set = 1'b1;
                    end else if (w_last_int && !si_eop) begin
                        w_err       = 1'b1;
                        w_state_nxt = DRAIN;
                    end
                end
`endif
            end
`ifdef PAD_STREAM_ASYM_FRAME_CHECK_EN
            DRAIN: begin
                si_ready = 1'b1;
                if (si_valid && si_eop) begin
                    w_state_nxt = r_done ? HDR_X : PIXEL;
                end
            end
`endif
            default: w_state_nxt = HDR_X;
        endcase
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            r_state    <= HDR_X;
            r_xres     <= '0;
            r_yres     <= '0;
            r_pad      <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_so_valid <= 1'b0;
            r_so_sop   <= 1'b0;
            r_so_eop   <= 1'b0;
            r_so_data  <= '0;
`ifdef PAD_STREAM_ASYM_FRAME_CHECK_EN
            r_early    <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_cap_x) begin
                r_xres <= si_data[DIM_W-1:0];
                r_pad  <= pad_value;
            end
            if (w_cap_y) begin
                r_yres <= si_data[DIM_W-1:0];
            end
            if (w_cnt_clr) begin
                r_cx <= '0;
                r_cy <= '0;
            end else if (w_adv) begin
                if (w_last_x) begin
                    r_cx <= '0;
                    r_cy <= r_cy + CW'(1);
                end else begin
                    r_cx <= r_cx + CW'(1);
                end
            end
            if (w_load) begin
                r_so_valid <= 1'b1;
                r_so_sop   <= w_ld_sop;
                r_so_eop   <= w_ld_eop;
                r_so_data  <= w_ld_data;
            end else if (so_ready) begin
                r_so_valid <= 1'b0;
                r_so_sop   <= 1'b0;
                r_so_eop   <= 1'b0;
            end
`ifdef PAD_STREAM_ASYM_FRAME_CHECK_EN
            r_err <= w_err;
            if (w_cnt_clr) begin
                r_early <= 1'b0;
            end else if (w_early_set) begin
                r_early <= 1'b1;
            end
            // Remember whether the frame already closed when we enter DRAIN.
            if (r_state == PIXEL && w_state_nxt == DRAIN) begin
                r_done <= w_last;
            end
`endif
        end
    end

    assign so_valid = r_so_valid;
    assign so_sop   = r_so_sop;
    assign so_eop   = r_so_eop;
    assign so_data  = r_so_data;

endmodule
